// File: rtl/rv32i_soc_fpga_top.sv
// rv32i_soc_fpga_top: FPGA I/O top of the rv32i SoC.
// Memory-mapped slave bus with scratch RAM, 16-bit switch/LED GPIO and an 8N1 UART.
// Optional macro UART_FLOW_CTRL_EN: RTS-gated TX start and CTS = rx_valid.
module rv32i_soc_fpga_top #(
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned BAUD_DIV  = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    input  logic        UART_TXD_IN,
    output logic        UART_RXD_OUT,
    input  logic        UART_RTS,
    output logic        UART_CTS
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    localparam logic [29:0] W_LED    = 30'h0800_0000;
    localparam logic [29:0] W_SW     = 30'h0800_0001;
    localparam logic [29:0] W_TXDATA = 30'h0800_0040;
    localparam logic [29:0] W_STATUS = 30'h0800_0041;
    localparam logic [29:0] W_RXDATA = 30'h0800_0042;

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic        accept;
    logic [29:0] word;
    logic        sel_ram;
    logic [AW-1:0] ram_idx;
    logic        unused_addr;

    assign accept      = req & ~ack;
    assign word        = addr[31:2];
    assign sel_ram     = (addr[31:AW+2] == '0);
    assign ram_idx     = addr[AW+1:2];
    assign unused_addr = ^addr[1:0];

    // ---------------- state ----------------
    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] ram_q;
    logic [31:0] rd_reg;
    logic        rd_ram;
    logic [31:0] reg_mux;
    logic [15:0] led_q;
    logic [15:0] sw_s1, sw_s2;

    tx_state_t   tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_frame;
    logic        tx_line;
    logic        tx_load, tx_go, tx_start, tx_busy;

    rx_state_t   rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_valid, rx_overrun, rx_frame_err;
    logic        rx_fall, rx_half, rx_tick, rx_done, rx_rd_clr;

    assign tx_busy   = (tx_state != TX_IDLE);
    assign tx_load   = accept & we & (word == W_TXDATA) & ~tx_busy;
    assign rx_rd_clr = accept & ~we & (word == W_RXDATA);

`ifdef UART_FLOW_CTRL_EN
    logic rts_s1, rts_s2;
    // Synchronize host RTS; reset to "not ready" until the pad is sampled
    always_ff @(posedge clk) begin
        if (reset) begin
            rts_s1 <= 1'b1;
            rts_s2 <= 1'b1;
        end else begin
            rts_s1 <= UART_RTS;
            rts_s2 <= rts_s1;
        end
    end
    assign tx_go    = ~rts_s2;
    assign UART_CTS = rx_valid;
`else
    logic unused_rts;
    assign unused_rts = UART_RTS;
    assign tx_go      = 1'b1;
    assign UART_CTS   = 1'b0;
`endif

    // RAM write with byte enables and unconditional registered read (no reset)
    always_ff @(posedge clk) begin
        if (accept && we && sel_ram) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_idx];
    end

    // Register-space read mux
    always_comb begin
        reg_mux = '0;
        if (word == W_LED)         reg_mux = {16'h0, led_q};
        else if (word == W_SW)     reg_mux = {16'h0, sw_s2};
        else if (word == W_STATUS) reg_mux = {28'h0, rx_frame_err, rx_overrun, rx_valid, tx_busy};
        else if (word == W_RXDATA) reg_mux = {24'h0, rx_byte};
    end

    // Bus handshake, registered read data, LED register and switch synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            ack    <= 1'b0;
            rd_reg <= '0;
            rd_ram <= 1'b0;
            led_q  <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            ack    <= accept;
            rd_ram <= accept & ~we & sel_ram;
            rd_reg <= (accept && !we && !sel_ram) ? reg_mux : '0;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            if (accept && we && word == W_LED) begin
                if (be[0]) led_q[7:0]  <= wdata[7:0];
                if (be[1]) led_q[15:8] <= wdata[15:8];
            end
        end
    end

    assign rdata = rd_ram ? ram_q : rd_reg;
    assign LED   = led_q;

    // ---------------- UART TX ----------------
    assign tx_start = ((tx_state == TX_IDLE) && tx_load && tx_go) ||
                      ((tx_state == TX_WAIT) && tx_go);

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next-state: idle -> (wait for RTS) -> send ten bits -> idle
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_load) tx_next = tx_go ? TX_SEND : TX_WAIT;
            TX_WAIT: if (tx_go)   tx_next = TX_SEND;
            TX_SEND: if (tx_cnt == BIT_LAST && tx_bit == 4'd9) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: frame shifter, baud counter and registered line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_frame <= '1;
        end else begin
            if (tx_load) tx_frame <= {1'b1, wdata[7:0], 1'b0};
            if (tx_start) begin
                tx_line <= 1'b0;
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end else if (tx_state == TX_SEND) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_line <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 4'd1;
                        tx_line  <= tx_frame[1];
                        tx_frame <= {1'b1, tx_frame[9:1]};
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    assign UART_RXD_OUT = tx_line;

    // ---------------- UART RX ----------------
    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_done = (rx_state == RX_STOP) && rx_tick;

    // RX line synchronizer plus edge-detect history, idle-high after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= UART_TXD_IN;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next-state: start-bit check at half bit, eight data bits, stop bit
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: baud counter, bit counter, LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                default: rx_cnt <= '0;
            endcase
        end
    end

    // RX status: a completing byte beats a same-cycle RXDATA read; that read
    // still consumed the previous byte, so it does not count as an overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else if (rx_done) begin
            rx_byte      <= rx_shift;
            rx_valid     <= 1'b1;
            rx_overrun   <= rx_rd_clr ? 1'b0 : (rx_overrun | rx_valid);
            rx_frame_err <= (rx_rd_clr ? 1'b0 : rx_frame_err) | ~rx_s2;
        end else if (rx_rd_clr) begin
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_soc_fpga_top.sv
// Directed self-checking bench for rv32i_soc_fpga_top with BAUD_DIV = 16.
module tb_rv32i_soc_fpga_top;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        ack;
    logic [15:0] SW, LED;
    logic        UART_TXD_IN, UART_RXD_OUT, UART_RTS, UART_CTS;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_soc_fpga_top #(.RAM_DEPTH(1024), .BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .SW(SW), .LED(LED),
        .UART_TXD_IN(UART_TXD_IN), .UART_RXD_OUT(UART_RXD_OUT),
        .UART_RTS(UART_RTS), .UART_CTS(UART_CTS)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; returns at 1ns after the ack edge with req already released
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] r);
        int lat;
        @(negedge clk);
        if (ack) @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        r = rdata;
        req = 1'b0; we = 1'b0;
        check("ack_latency", lat, 1);
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            UART_TXD_IN = f[k];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk);
        UART_TXD_IN = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  fr;
        logic        exp_cts;

        exp_cts = 1'b0;
`ifdef UART_FLOW_CTRL_EN
        exp_cts = 1'b1;
`endif
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        SW = '0; UART_TXD_IN = 1'b1; UART_RTS = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", {16'h0, LED}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_txline", {31'h0, UART_RXD_OUT}, 32'h1);
        check("rst_cts", {31'h0, UART_CTS}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        bus(1'b0, 32'h2000_0000, 32'h0, 4'hF, r);
        check("rd_led_rst", r, 32'h0);

        // RAM byte enables, top word, unmapped space and no aliasing past RAM
        bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, r);
        bus(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, r);
        bus(1'b0, 32'h0000_0010, 32'h0, 4'hF, r);
        check("ram_be", r, 32'hDEAD_BEAA);
        bus(1'b0, 32'h3000_0000, 32'h0, 4'hF, r);
        check("unmapped_rd", r, 32'h0);
        bus(1'b1, 32'h0000_0FFC, 32'h1122_3344, 4'hF, r);
        bus(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, r);
        check("ram_top", r, 32'h1122_3344);
        bus(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, r);
        bus(1'b1, 32'h0000_1000, 32'h0BAD_BEEF, 4'hF, r);
        bus(1'b0, 32'h0000_0000, 32'h0, 4'hF, r);
        check("ram_noalias", r, 32'hCAFE_F00D);
        bus(1'b0, 32'h0000_1000, 32'h0, 4'hF, r);
        check("past_ram_rd", r, 32'h0);

        // GPIO
        SW = 16'hA5C3;
        repeat (3) @(posedge clk);
        bus(1'b0, 32'h2000_0004, 32'h0, 4'hF, r);
        check("sw_rd", r, 32'h0000_A5C3);
        bus(1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, r);
        check("led_out", {16'h0, LED}, 32'h5678);
        bus(1'b0, 32'h2000_0000, 32'h0, 4'hF, r);
        check("led_rd", r, 32'h0000_5678);
        bus(1'b1, 32'h2000_0000, 32'hFFFF_AB00, 4'b0010, r);
        check("led_be1", {16'h0, LED}, 32'hAB78);
        bus(1'b1, 32'h2000_0000, 32'hFFFF_FFFF, 4'b1100, r);
        check("led_be_hi", {16'h0, LED}, 32'hAB78);
        bus(1'b0, 32'h2000_0100, 32'h0, 4'hF, r);
        check("txdata_rd", r, 32'h0);

        // TX 0x55: accept edge E0; status read at E2; dropped write at E4
        bus(1'b1, 32'h2000_0100, 32'h0000_0055, 4'hF, r);
        check("tx_start_bit", {31'h0, UART_RXD_OUT}, 32'h0);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("tx_busy", r, 32'h1);
        bus(1'b1, 32'h2000_0100, 32'h0000_00AA, 4'hF, r);
        fr = {1'b1, 8'h55, 1'b0};
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                repeat (BD) @(posedge clk);
                #1;
            end
            check($sformatf("tx_bit%0d", k), {31'h0, UART_RXD_OUT}, {31'h0, fr[k]});
        end
        repeat (6) @(posedge clk);
        #1;
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("tx_busy_last", r, 32'h1);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("tx_busy_drop", r, 32'h0);
        check("tx_idle_line", {31'h0, UART_RXD_OUT}, 32'h1);

        // RX: glitch rejected, then a clean byte
        @(negedge clk);
        UART_TXD_IN = 1'b0;
        repeat (3) @(negedge clk);
        UART_TXD_IN = 1'b1;
        repeat (30) @(negedge clk);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_glitch", r, 32'h0);

        uart_send(8'h3C, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("cts_valid", {31'h0, UART_CTS}, {31'h0, exp_cts});
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_status", r, 32'h2);
        bus(1'b0, 32'h2000_0108, 32'h0, 4'hF, r);
        check("rx_data", r, 32'h3C);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_cleared", r, 32'h0);
        check("cts_clear", {31'h0, UART_CTS}, 32'h0);

        uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_overrun", r, 32'h6);
        bus(1'b0, 32'h2000_0108, 32'h0, 4'hF, r);
        check("rx_second", r, 32'h22);

        uart_send(8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_frame_err", r, 32'hA);
        bus(1'b0, 32'h2000_0108, 32'h0, 4'hF, r);
        check("rx_ferr_data", r, 32'h5A);
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rx_ferr_clr", r, 32'h0);

`ifdef UART_FLOW_CTRL_EN
        UART_RTS = 1'b1;
        repeat (4) @(posedge clk);
        bus(1'b1, 32'h2000_0100, 32'h0000_0081, 4'hF, r);
        repeat (20) @(posedge clk);
        #1;
        check("fc_hold_line", {31'h0, UART_RXD_OUT}, 32'h1);
        @(negedge clk);
        UART_RTS = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("fc_started", {31'h0, UART_RXD_OUT}, 32'h0);
        repeat (10 * BD + 4) @(posedge clk);
`endif

        // Reset mid-frame forces the line idle and clears busy and LED
        bus(1'b1, 32'h2000_0100, 32'h0000_0000, 4'hF, r);
        repeat (20) @(posedge clk);
        #1;
        check("tx_mid_low", {31'h0, UART_RXD_OUT}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_line", {31'h0, UART_RXD_OUT}, 32'h1);
        check("rst_mid_led", {16'h0, LED}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, r);
        check("rst_mid_status", r, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
